tff_chain_sequencer: RTL and testbench

Controller that sequences a bank of WIDTH enable-gated toggle flip-flops as a synchronous up-counter running from 0 to a programmed terminal value. It is started and stopped by a start/stop handshake and reports completion with a one-cycle DONE pulse. It generates the per-bit toggle enables, owns the run/finish state machine, and is the block the lab's divider and timer exercises instantiate instead of wiring toggle flip-flops by hand.

---
 rtl/tff_chain_pkg.sv | 19 +
 rtl/tff_chain_sequencer_tff_cell.sv | 36 +++
 rtl/tff_chain_sequencer.sv | 149 ++++++++++++++
 tb/tb_tff_chain_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tff_chain_pkg.sv
// Shared types and defaults for the toggle-flip-flop chain sequencer.
// The state encoding is fixed so that waveforms and lab handouts can quote
// the raw state values.
package tff_chain_pkg;

    // Controller states: waiting for START, counting, and the one-cycle finish
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    // Default number of toggle cells in the bank
    localparam int TFF_WIDTH_DEFAULT = 4;

    // Default width of the step divider when the prescaler is built in
    localparam int TFF_PRESCALE_W_DEFAULT = 4;

endpackage

// File: rtl/tff_chain_sequencer_tff_cell.sv
// Single toggle flip-flop cell: asynchronous active-high reset, synchronous
// clear and toggle enable. Clear wins over enable so that a restart always
// lands on zero even if the enable chain happens to be active.
module tff_cell (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic ten_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next value: clear first, otherwise toggle when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (ten_i) begin
            q_d = ~q_q;
        end
    end

    // Cell storage, forced to zero immediately by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_chain_sequencer.sv
// Sequencer for a bank of WIDTH toggle cells that counts 0..LIMIT after a
// START, aborts on STOP, and pulses DONE for one cycle when the limit is
// reached. The cells themselves live in tff_cell; this level owns the FSM,
// the captured limit and the ripple-style enable chain.
// Optional feature macro: TFF_CHAIN_SEQUENCER_PRESCALE_EN adds the PRESCALE
// port and a prescale counter that spaces count steps PRESCALE+1 cycles apart.
module tff_chain_sequencer
    import tff_chain_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH_DEFAULT
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = TFF_PRESCALE_W_DEFAULT
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [WIDTH-1:0]      LIMIT,
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] PRESCALE,
`endif
    output logic [WIDTH-1:0]      COUNT,
    output logic [WIDTH-1:0]      TEN,
    output logic                  BUSY,
    output logic                  DONE
);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_d;

    logic             clrCells;
    logic [WIDTH-1:0] tenVec;
    logic [WIDTH-1:0] chainTen;
    logic             carry;
    logic             stepPoint;
    logic             atLimit;

`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_d;
    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // A step happens once the prescale counter reaches the captured divider
    assign stepPoint = (pcnt_q == presc_q);
`else
    // Without the prescaler every RUN cycle advances the count
    assign stepPoint = 1'b1;
`endif

    assign atLimit = (COUNT == limit_q);

    // Increment enables: bit i toggles when every lower bit is already one
    always_comb begin
        chainTen = '0;
        carry    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            chainTen[i] = carry;
            carry       = carry & COUNT[i];
        end
    end

    // Next-state and output decode for the IDLE/RUN/FIN controller
    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        clrCells = 1'b0;
        tenVec   = '0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    limit_d  = LIMIT;
                    clrCells = 1'b1;
                    state_d  = S_RUN;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
                    presc_d  = PRESCALE;
                    pcnt_d   = '0;
`endif
                end
            end
            S_RUN: begin
                BUSY = 1'b1;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
                pcnt_d = stepPoint ? '0 : pcnt_q + 1'b1;
`endif
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (stepPoint) begin
                    if (atLimit) begin
                        state_d = S_FIN;
                    end else begin
                        tenVec = chainTen;
                    end
                end
            end
            S_FIN: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign TEN = tenVec;

    // Controller registers: state, captured limit and prescale bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            limit_q <= '0;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
            presc_q <= '0;
            pcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
`endif
        end
    end

    // One toggle cell per count bit, all sharing the restart clear
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .clr_i (clrCells),
            .ten_i (tenVec[g]),
            .q_o   (COUNT[g])
        );
    end

endmodule

// File: tb/tb_tff_chain_sequencer.sv
// Self-checking bench for tff_chain_sequencer (WIDTH=4). The driver pushes the
// hand-computed outputs expected for each cycle into a queue; a monitor on the
// falling edge pops and compares them against COUNT/BUSY/DONE/TEN.
module tb_tff_chain_sequencer;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         STOP;
    logic [W-1:0] LIMIT;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
    logic [3:0]   PRESCALE;
`endif
    logic [W-1:0] COUNT;
    logic [W-1:0] TEN;
    logic         BUSY;
    logic         DONE;

    typedef struct {
        logic [2*W+1:0] vec;
        string          tag;
    } exp_t;

    exp_t         expQ[$];
    int           passCount  = 0;
    int           checkCount = 0;
    logic [W-1:0] lastCount;

    always #5 CLK = ~CLK;

    tff_chain_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .STOP     (STOP),
        .LIMIT    (LIMIT),
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
        .PRESCALE (PRESCALE),
`endif
        .COUNT    (COUNT),
        .TEN      (TEN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // Bits that change when n increments by one
    function automatic logic [W-1:0] tenFor(input logic [W-1:0] n);
        logic [W-1:0] nxt;
        nxt = n + 1'b1;
        return n ^ nxt;
    endfunction

    task automatic checkOutput(input string tag, input logic [2*W+1:0] act,
                               input logic [2*W+1:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got count=%0d busy=%b done=%b ten=%b, expected count=%0d busy=%b done=%b ten=%b",
                     tag, act[2*W+1 -: W], act[W+1], act[W], act[W-1:0],
                     exp[2*W+1 -: W], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    // Drive inputs for the current cycle, queue its expected outputs, advance
    task automatic applyStimulus(input logic start, input logic stop,
                                 input logic [W-1:0] limit,
                                 input logic [W-1:0] expCount, input logic expBusy,
                                 input logic expDone, input logic [W-1:0] expTen,
                                 input string tag);
        exp_t e;
        START = start;
        STOP  = stop;
        LIMIT = limit;
        e.vec = {expCount, expBusy, expDone, expTen};
        e.tag = tag;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Full run from START through FIN, optionally with START noise and a
    // different LIMIT presented while running
    task automatic runCount(input logic [W-1:0] limit, input logic startNoise,
                            input logic [W-1:0] midLimit);
        logic [W-1:0] c;
        applyStimulus(1'b1, 1'b0, limit, lastCount, 1'b0, 1'b0, '0,
                      $sformatf("L%0d start", limit));
        for (int n = 0; n <= int'(limit); n++) begin
            c = n[W-1:0];
            applyStimulus(startNoise, 1'b0, midLimit, c, 1'b1, 1'b0,
                          (c == limit) ? '0 : tenFor(c),
                          $sformatf("L%0d run n=%0d", limit, n));
        end
        applyStimulus(startNoise, 1'b0, midLimit, limit, 1'b0, 1'b1, '0,
                      $sformatf("L%0d fin", limit));
        lastCount = limit;
    endtask

    // Scoreboard monitor: compare each queued expectation mid-cycle
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, {COUNT, BUSY, DONE, TEN}, e.vec);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        LIMIT = '0;
`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
        PRESCALE = '0;
`endif
        lastCount = '0;
        #3;
        checkOutput("reset values", {COUNT, BUSY, DONE, TEN}, '0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, '0, "idle after reset");
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, '0, "idle hold");

        runCount(4'd6, 1'b0, 4'd6);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd6, 1'b0, 1'b0, '0, "idle after L6");

        runCount(4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, '0, "idle after L0");

        runCount(4'd15, 1'b0, 4'd15);
        applyStimulus(1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, '0, "no wrap after L15");

        // Abort at COUNT=3 and simultaneous START/STOP in IDLE
        applyStimulus(1'b1, 1'b0, 4'd10, lastCount, 1'b0, 1'b0, '0, "stop-run start");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b0, 4'd10, n[W-1:0], 1'b1, 1'b0, tenFor(n[W-1:0]),
                          $sformatf("stop-run n=%0d", n));
        end
        applyStimulus(1'b0, 1'b1, 4'd10, 4'd3, 1'b1, 1'b0, '0, "stop asserted");
        applyStimulus(1'b0, 1'b0, 4'd10, 4'd3, 1'b0, 1'b0, '0, "idle after stop");
        applyStimulus(1'b1, 1'b1, 4'd5, 4'd3, 1'b0, 1'b0, '0, "start with stop");
        applyStimulus(1'b0, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, '0, "still idle");
        lastCount = 4'd3;

        // START noise during RUN/FIN, LIMIT change mid-run, back-to-back restart
        runCount(4'd2, 1'b1, 4'd9);
        runCount(4'd3, 1'b0, 4'd3);
        applyStimulus(1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, '0, "idle after restart");

        // Asynchronous reset while counting
        applyStimulus(1'b1, 1'b0, 4'd10, lastCount, 1'b0, 1'b0, '0, "rst-run start");
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b0, 1'b0, 4'd10, n[W-1:0], 1'b1, 1'b0, tenFor(n[W-1:0]),
                          $sformatf("rst-run n=%0d", n));
        end
        #1;
        checkOutput("before reset", {COUNT, BUSY, DONE, TEN}, {4'd5, 1'b1, 1'b0, 4'b0011});
        RST = 1'b1;
        #1;
        checkOutput("async reset mid-run", {COUNT, BUSY, DONE, TEN}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        lastCount = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd10, 4'd0, 1'b0, 1'b0, '0,
                          $sformatf("idle after reset %0d", i));
        end

`ifdef TFF_CHAIN_SEQUENCER_PRESCALE_EN
        // PRESCALE=2, LIMIT=2: steps at k+3, k+6, finish at k+9
        PRESCALE = 4'd2;
        applyStimulus(1'b1, 1'b0, 4'd2, lastCount, 1'b0, 1'b0, '0, "presc start");
        PRESCALE = 4'd0;
        for (int j = 0; j < 9; j++) begin
            logic [W-1:0] c;
            c = 4'(j / 3);
            applyStimulus(1'b0, 1'b0, 4'd9, c, 1'b1, 1'b0,
                          ((j % 3 == 2) && (c != 4'd2)) ? tenFor(c) : '0,
                          $sformatf("presc run j=%0d", j));
        end
        applyStimulus(1'b0, 1'b0, 4'd9, 4'd2, 1'b0, 1'b1, '0, "presc fin");
        applyStimulus(1'b0, 1'b0, 4'd9, 4'd2, 1'b0, 1'b0, '0, "presc idle");
`endif

        for (int i = 0; i < 5 && expQ.size() != 0; i++) begin
            @(negedge CLK);
        end
        #1;
        checkCount++;
        if (expQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
